// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared state encoding and default keycodes for game_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    // Encodings are read directly by the sprite/colour mapper; do not reorder.
    typedef enum logic [1:0] {
        MENU      = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2,
        PAUSE     = 2'd3
    } state_e;

    localparam logic [7:0] c_ESC_CODE   = 8'd41;
    localparam logic [7:0] c_ENTER_CODE = 8'd40;
    localparam logic [7:0] c_PAUSE_CODE = 8'd19;

endpackage

`default_nettype wire

// File: rtl/game_fsm_key_edge_detect.sv
// ============================================================================
// Module      : key_edge_detect
// Description : Matches one keycode across all keyboard slots; press edge out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_edge_detect #(
    parameter int              NUM_KEYS = 4,
    parameter int              KEY_W    = 8,
    parameter logic [KEY_W-1:0] CODE    = '0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_KEYS*KEY_W-1:0] keycode,
    output logic                      pressed,
    output logic                      press_edge
);

    logic w_pressed;
    logic r_prev;

    // Duplicate slots collapse into a single press via the OR-reduction.
    always_comb begin
        w_pressed = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycode[i*KEY_W +: KEY_W] == CODE) begin
                w_pressed = 1'b1;
            end
        end
    end

    // Prev starts high so a key held through reset must be re-pressed.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_pressed;
        end
    end

    assign pressed    = w_pressed;
    assign press_edge = w_pressed & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/game_fsm.sv
// ============================================================================
// Module      : game_fsm
// Description : Game-flow controller (MENU/PLAY/PAUSE/GAME_OVER), high score.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_fsm
    import game_pkg::*;
#(
    parameter int                NUM_KEYS    = 4,
    parameter int                KEY_W       = 8,
    parameter int                HEALTH_W    = 10,
    parameter int                SCORE_W     = 16,
    parameter int                OVER_FRAMES = 120,
    parameter bit                AUTO_RETURN = 1'b1,
    parameter logic [KEY_W-1:0]  ESC_CODE    = KEY_W'(c_ESC_CODE),
    parameter logic [KEY_W-1:0]  ENTER_CODE  = KEY_W'(c_ENTER_CODE),
    parameter logic [KEY_W-1:0]  PAUSE_CODE  = KEY_W'(c_PAUSE_CODE)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_tick,
    input  logic [NUM_KEYS*KEY_W-1:0] keycode,
    input  logic [HEALTH_W-1:0]       health,
    input  logic [SCORE_W-1:0]        score,
    output logic [7:0]                state,
    output logic                      run_en,
    output logic                      game_reset,
    output logic [SCORE_W-1:0]        high_score,
    output logic                      over_done
);

    // A zero hold time still needs a one-bit counter.
    localparam int                CNT_W      = (OVER_FRAMES > 0) ? $clog2(OVER_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0]  c_OVER_MAX = CNT_W'(OVER_FRAMES);

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_high_score;
    logic               r_game_reset;
    logic               w_over_done;
    logic               w_esc_edge;
    logic               w_enter_edge;
    logic               w_pause_edge;
    logic               w_esc_pressed;
    logic               w_enter_pressed;
    logic               w_pause_pressed;

    key_edge_detect #(.NUM_KEYS(NUM_KEYS), .KEY_W(KEY_W), .CODE(ESC_CODE)) u_esc (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .pressed(w_esc_pressed), .press_edge(w_esc_edge)
    );

    key_edge_detect #(.NUM_KEYS(NUM_KEYS), .KEY_W(KEY_W), .CODE(ENTER_CODE)) u_enter (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .pressed(w_enter_pressed), .press_edge(w_enter_edge)
    );

    key_edge_detect #(.NUM_KEYS(NUM_KEYS), .KEY_W(KEY_W), .CODE(PAUSE_CODE)) u_pause (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .pressed(w_pause_pressed), .press_edge(w_pause_edge)
    );

    // State register plus the registered side effects of each transition.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= MENU;
            r_cnt        <= '0;
            r_high_score <= '0;
            r_game_reset <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_game_reset <= (w_next_state == PLAY) &&
                            ((r_state == MENU) || (r_state == GAME_OVER));
            if ((r_state == PLAY) && (w_next_state == GAME_OVER) && (score > r_high_score)) begin
                r_high_score <= score;
            end
            if (r_state != GAME_OVER) begin
                r_cnt <= '0;
            end else if (frame_tick && (r_cnt != c_OVER_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MENU: begin
                if (w_enter_edge) w_next_state = PLAY;
            end
            PLAY: begin
                if (health == '0)      w_next_state = GAME_OVER;
                else if (w_esc_edge)   w_next_state = MENU;
                else if (w_pause_edge) w_next_state = PAUSE;
            end
            PAUSE: begin
                if (w_esc_edge)                        w_next_state = MENU;
                else if (w_enter_edge || w_pause_edge) w_next_state = PLAY;
            end
            GAME_OVER: begin
                // An early Enter is dropped, not queued.
                if (w_esc_edge)                       w_next_state = MENU;
                else if (w_enter_edge && w_over_done) w_next_state = PLAY;
                else if (AUTO_RETURN && w_over_done)  w_next_state = MENU;
            end
            default: w_next_state = MENU;
        endcase
    end

    always_comb begin
        w_over_done = (r_state == GAME_OVER) && (r_cnt == c_OVER_MAX);
        state       = {6'b0, r_state};
        run_en      = (r_state == PLAY);
        game_reset  = r_game_reset;
        high_score  = r_high_score;
        over_done   = w_over_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_game_fsm.sv
// ============================================================================
// Module      : tb_game_fsm
// Description : Directed self-checking bench for game_fsm (manual/auto return).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_fsm;

    localparam logic [31:0] c_KC_ENTER_S2 = 32'h0028_0000;
    localparam logic [31:0] c_KC_ENTER_S0 = 32'h0000_0028;
    localparam logic [31:0] c_KC_P_S0     = 32'h0000_0013;
    localparam logic [31:0] c_KC_ESC_S1   = 32'h0000_2900;

    logic        Clk;
    logic        Reset;
    // Instance A: manual return, instance B: auto return; both hold 4 frames.
    logic        ft_a, ft_b;
    logic [31:0] kc_a, kc_b;
    logic [9:0]  hp_a, hp_b;
    logic [15:0] sc_a, sc_b;
    logic [7:0]  st_a, st_b;
    logic        run_a, run_b, gr_a, gr_b, od_a, od_b;
    logic [15:0] hs_a, hs_b;

    int n_cmp = 0;
    int n_bad = 0;

    game_fsm #(.OVER_FRAMES(4), .AUTO_RETURN(1'b0)) dut_a (
        .Clk(Clk), .Reset(Reset), .frame_tick(ft_a), .keycode(kc_a),
        .health(hp_a), .score(sc_a), .state(st_a), .run_en(run_a),
        .game_reset(gr_a), .high_score(hs_a), .over_done(od_a)
    );

    game_fsm #(.OVER_FRAMES(4), .AUTO_RETURN(1'b1)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_tick(ft_b), .keycode(kc_b),
        .health(hp_b), .score(sc_b), .state(st_b), .run_en(run_b),
        .game_reset(gr_b), .high_score(hs_b), .over_done(od_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        ft_a = 1'b0; ft_b = 1'b0;
        kc_a = c_KC_ENTER_S2; kc_b = '0;
        hp_a = 10'd100; hp_b = 10'd100;
        sc_a = '0; sc_b = '0;
        #2;
        check_eq("rst_state", st_a, 0);
        check_eq("rst_run_en", run_a, 0);
        check_eq("rst_game_reset", gr_a, 0);
        check_eq("rst_high_score", hs_a, 0);
        check_eq("rst_over_done", od_a, 0);
        #10 Reset = 1'b1;

        // Enter held through reset release must not start a game.
        step(2);
        check_eq("held_enter_menu", st_a, 0);
        kc_a = '0;
        step(1);
        kc_a = c_KC_ENTER_S2;
        step(1);
        check_eq("enter_play", st_a, 1);
        check_eq("enter_game_reset", gr_a, 1);
        check_eq("enter_run_en", run_a, 1);
        kc_a = '0;
        step(1);
        check_eq("game_reset_one_cycle", gr_a, 0);

        kc_a = c_KC_P_S0;
        step(1);
        check_eq("pause_state", st_a, 3);
        check_eq("pause_run_en", run_a, 0);
        step(1);
        check_eq("p_held_stays_pause", st_a, 3);
        kc_a = '0;
        step(1);
        kc_a = c_KC_P_S0;
        step(1);
        check_eq("resume_state", st_a, 1);
        check_eq("resume_no_game_reset", gr_a, 0);
        kc_a = '0;
        step(1);

        // Death wins over a simultaneous Esc.
        sc_a = 16'd500; hp_a = '0; kc_a = c_KC_ESC_S1;
        step(1);
        check_eq("die_over_esc_state", st_a, 2);
        check_eq("die_high_score", hs_a, 500);
        check_eq("die_over_done_low", od_a, 0);
        kc_a = '0; hp_a = 10'd100;
        for (int i = 0; i < 2; i++) begin
            ft_a = 1'b1; step(1); ft_a = 1'b0; step(1);
        end
        kc_a = c_KC_ENTER_S0;
        step(1);
        check_eq("early_enter_ignored", st_a, 2);
        kc_a = '0;
        ft_a = 1'b1; step(1); ft_a = 1'b0; step(1);
        check_eq("three_ticks_not_done", od_a, 0);
        ft_a = 1'b1; step(1); ft_a = 1'b0;
        check_eq("four_ticks_done", od_a, 1);
        ft_a = 1'b1; step(1); ft_a = 1'b0; step(2);
        check_eq("saturated_done", od_a, 1);
        check_eq("no_auto_return", st_a, 2);
        kc_a = c_KC_ENTER_S0;
        step(1);
        check_eq("restart_state", st_a, 1);
        check_eq("restart_game_reset", gr_a, 1);
        kc_a = '0;
        sc_a = 16'd300; hp_a = '0;
        step(1);
        check_eq("die2_state", st_a, 2);
        check_eq("die2_keeps_high", hs_a, 500);
        hp_a = 10'd100; kc_a = c_KC_ESC_S1;
        step(1);
        check_eq("esc_to_menu", st_a, 0);
        check_eq("high_persists", hs_a, 500);
        kc_a = '0;

        // Auto-return instance.
        kc_b = c_KC_ENTER_S0;
        step(1);
        check_eq("b_play", st_b, 1);
        kc_b = '0; sc_b = 16'd700; hp_b = '0;
        step(1);
        check_eq("b_over", st_b, 2);
        check_eq("b_high", hs_b, 700);
        hp_b = 10'd10; ft_b = 1'b1;
        step(4);
        ft_b = 1'b0;
        check_eq("b_done_rise", od_b, 1);
        check_eq("b_still_over", st_b, 2);
        step(1);
        check_eq("b_auto_menu", st_b, 0);
        check_eq("b_menu_not_done", od_b, 0);

        kc_b = c_KC_ENTER_S0;
        step(1);
        check_eq("b_play2", st_b, 1);
        kc_b = '0; hp_b = '0;
        step(1);
        check_eq("b_over2", st_b, 2);
        check_eq("b_tie_keeps_high", hs_b, 700);
        hp_b = 10'd10; ft_b = 1'b1;
        step(4);
        ft_b = 1'b0;
        check_eq("b_done_rise2", od_b, 1);
        kc_b = c_KC_ENTER_S0;
        step(1);
        check_eq("b_enter_beats_auto", st_b, 1);
        check_eq("b_enter_game_reset", gr_b, 1);
        kc_b = '0;
        step(1);

        // Asynchronous reset between edges.
        #3 Reset = 1'b0;
        #1;
        check_eq("async_state", st_b, 0);
        check_eq("async_run_en", run_b, 0);
        check_eq("async_high_b", hs_b, 0);
        check_eq("async_high_a", hs_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
